seg7_serial_rx: RTL and testbench
=================================

# seg7_serial_rx

Serial-frame receiver and decoder for the 4-digit + colon 7-segment display link. It deserializes the 16-bit frames carried on the display clock/load/data wires and recovers the BCD digit and colon values that produced them. It sits on the display side of the link as a board-level monitor and loopback checker. It is also the self-check engine for the display driver in system simulation.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer depth on sclk/load/sdata; legal 1..4.
- TIMEOUT, 255: max clk cycles in SHIFT with no sclk rising edge before abort; legal 16..65535.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sclk  in  1  display shift clock; idles low.
- load  in  1  frame strobe; low while a frame is shifting, high when idle; rising edge latches the frame.
- sdata  in  1  serial data, MSB first, stable on sclk rising edge.
- digit0..digit3  out  4 each  last decoded hex value per digit; digit0 is the least significant digit.
- colon  out  2  last received colon code (00 colon, 01 decimal point, 11 none).
- frame_valid  out  1  one-cycle pulse when a good frame updates an output.
- frame_err  out  1  one-cycle pulse on any rejected frame.
- scan_done  out  1  one-cycle pulse when all 5 slots (4 digits + colon) have been updated since the previous scan_done or reset.

## Operation
- Frame format: 16 bits, MSB first. Bits 15:8 are the segment byte. Bits 7:0 are the enable byte: {colon_sel, 3'b000, dig_en[3:0]}.
- Segment byte is active low, ordered {DP,g,f,e,d,c,b,a}. DP (bit 7) is ignored.
- Decode on segment byte bits 6:0, one code per value:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:03, 7:78
  - 8:00, 9:18, A:08, C:27, D:21, E:06, F:0E
- Code 03 decodes to 4'h6. The driver emits 03 for both 6 and B; B is never reported.
- Enable byte must be one-hot over {bit7, bits3:0}, with bits 6:4 equal to zero. Any other value gives frame_err.
- bit7 set (colon slot): colon <= segment byte[1:0]. Segment byte[7:2] must be 0, else frame_err.
- dig_en[n] set: digitn <= decoded value. An unlisted segment code gives frame_err, and digitn is left unchanged.
- sclk, load and sdata all pass through identical SYNC_STAGES flops, so their relative alignment is preserved. Edges are detected on the synchronized copies.
- State machine:
  - WAIT_IDLE: stay until synchronized load is high, then go to IDLE. This is the state entered on reset.
  - IDLE: on load falling edge, clear the bit counter and go to SHIFT.
  - SHIFT: on each sclk rising edge, shift sdata into a 16-bit register; the counter saturates at 17.
  - SHIFT, on load rising edge: if count == 16 go to DECODE; otherwise pulse frame_err and go to IDLE.
  - SHIFT timeout: TIMEOUT cycles without an sclk rise pulses frame_err and goes to WAIT_IDLE.
  - DECODE (1 cycle): check, update outputs, pulse frame_valid or frame_err, then go to IDLE.
- sclk rise and load rise in the same cycle: the bit is shifted first, then the count is evaluated.
- Slot mask (5 bits): set on each valid update. When it reaches all ones, scan_done pulses together with that frame_valid, and the mask clears in the same cycle.
- Reset values: digit0..3 = 0, colon = 2'b11, frame_valid = frame_err = scan_done = 0, slot mask = 0, state = WAIT_IDLE.
- Reset mid-frame: the partial frame is discarded without frame_err. A frame already in progress when reset releases is ignored via WAIT_IDLE.

## Timing
- sclk high and low phases must each be ≥1 clk period when sclk shares this clk, and ≥2 periods when asynchronous.
- Latency: frame_valid / frame_err / output update is SYNC_STAGES+2 clk cycles after the first clk edge that samples load high at the pin.
- Outputs are registered and hold their value between frames.
- Back-to-back frames need load high for ≥2 synchronized cycles. A shorter high is an unsupported input.
- Timeout counter resets on every sclk rising edge, and on entry to SHIFT.

## Test plan
- Driver-format frame, segment 0xF9, enable 0x01 -> digit0 = 1 and frame_valid pulses SYNC_STAGES+2 cycles after load rises; the other outputs are unchanged.
- Full scan of digits 9, 0, 4, F plus colon frame {0x00, 0x80} -> digit3..0 = 9,0,4,F and colon = 00. scan_done pulses exactly once, with the fifth frame_valid.
- Frame with 15 sclk rises, and separately one with 17 -> frame_err for each, no output change, and the next good frame is accepted.
- Enable 0x03, enable 0x10, segment 0x7F on digit1, and colon frame with segment 0x04 -> frame_err for each, outputs unchanged.
- Segment 0x83 on digit2 -> digit2 = 6. Then stall sclk low for TIMEOUT cycles mid-frame -> frame_err, and the receiver resyncs on the next load high.
- Assert reset at bit 8 of a frame and release with load still low -> no pulses and all reset values. The remainder of that frame is ignored, and the following frame decodes correctly.

Source files
------------

// File: rtl/seg7_serial_rx.sv
// seg7_serial_rx
// Receives the 16-bit serial frames sent to a 4-digit + colon 7-segment display.
// It recovers the hex digit and colon values that produced each frame.
// Frame layout, MSB first: {segment byte (active low DP,g..a), enable byte {colon_sel,3'b000,dig_en[3:0]}}.
//
// Ports:
//   clk, reset        system clock and synchronous active-high reset
//   sclk, load, sdata display link pins; each is synchronized here
//   digit0..digit3    last decoded value per digit (digit0 = least significant)
//   colon             last colon code (00 colon, 01 decimal point, 11 none)
//   frame_valid       one-cycle pulse when a good frame updates an output
//   frame_err         one-cycle pulse on any rejected frame
//   scan_done         one-cycle pulse when all 5 slots have been refreshed
module seg7_serial_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk,
    input  logic       load,
    input  logic       sdata,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [1:0] colon,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       scan_done
);

    localparam logic [1:0] ST_WAIT_IDLE = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;
    localparam logic [1:0] ST_DECODE    = 2'd3;

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    // All three pins go through the same chain, so sdata stays aligned with sclk.
    // Bit order inside each stage: {sclk, load, sdata}.
    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [2:0] q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) q <= 3'b000;
                    else       q <= {sclk, load, sdata};
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) q <= 3'b000;
                    else       q <= g_sync[gi-1].q;
                end
            end
        end
    endgenerate

    logic [2:0] sync_out;
    assign sync_out = g_sync[SYNC_STAGES-1].q;

    // Registered edge flags. sdata_d_reg holds the data that sits beside an sclk rise.
    logic sclk_prev_reg, load_prev_reg, load_lvl_reg;
    logic sclk_rise_reg, load_rise_reg, load_fall_reg, sdata_d_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_prev_reg <= 1'b0;
            load_prev_reg <= 1'b0;
            load_lvl_reg  <= 1'b0;
            sclk_rise_reg <= 1'b0;
            load_rise_reg <= 1'b0;
            load_fall_reg <= 1'b0;
            sdata_d_reg   <= 1'b0;
        end else begin
            sclk_prev_reg <= sync_out[2];
            load_prev_reg <= sync_out[1];
            load_lvl_reg  <= sync_out[1];
            sclk_rise_reg <= sync_out[2] & ~sclk_prev_reg;
            load_rise_reg <= sync_out[1] & ~load_prev_reg;
            load_fall_reg <= ~sync_out[1] & load_prev_reg;
            sdata_d_reg   <= sync_out[0];
        end
    end

    // Returns {known, value}. Code 03 maps to 6 only; B is never reported.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        case (s)
            7'h40: decode_seg = 5'h10;
            7'h79: decode_seg = 5'h11;
            7'h24: decode_seg = 5'h12;
            7'h30: decode_seg = 5'h13;
            7'h19: decode_seg = 5'h14;
            7'h12: decode_seg = 5'h15;
            7'h03: decode_seg = 5'h16;
            7'h78: decode_seg = 5'h17;
            7'h00: decode_seg = 5'h18;
            7'h18: decode_seg = 5'h19;
            7'h08: decode_seg = 5'h1A;
            7'h27: decode_seg = 5'h1C;
            7'h21: decode_seg = 5'h1D;
            7'h06: decode_seg = 5'h1E;
            7'h0E: decode_seg = 5'h1F;
            default: decode_seg = 5'h00;
        endcase
    endfunction

    logic [1:0]  state_reg, state_next;
    logic [4:0]  count_reg, count_next;
    logic [15:0] shift_reg, shift_next;
    logic [15:0] tcnt_reg, tcnt_next;
    logic [4:0]  mask_reg, mask_next;
    logic [3:0]  digit_reg [4];
    logic [3:0]  digit_next [4];
    logic [1:0]  colon_reg, colon_next;
    logic        valid_next, err_next, done_next;

    // Decode-stage helpers. sel5 = {colon_sel, dig_en[3:0]}, and it must be one-hot.
    logic [7:0] seg_byte, en_byte;
    logic [4:0] sel5, mask_or;
    logic [4:0] dec;
    logic       en_ok, frame_ok;

    assign seg_byte = shift_reg[15:8];
    assign en_byte  = shift_reg[7:0];
    assign sel5     = {en_byte[7], en_byte[3:0]};
    assign en_ok    = (sel5 != 5'd0) && ((sel5 & (sel5 - 5'd1)) == 5'd0) && (en_byte[6:4] == 3'b000);
    assign dec      = decode_seg(seg_byte[6:0]);
    assign frame_ok = en_ok && (en_byte[7] ? (seg_byte[7:2] == 6'd0) : dec[4]);
    assign mask_or  = mask_reg | sel5;

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        shift_next = shift_reg;
        tcnt_next  = tcnt_reg;
        mask_next  = mask_reg;
        colon_next = colon_reg;
        valid_next = 1'b0;
        err_next   = 1'b0;
        done_next  = 1'b0;
        for (int n = 0; n < 4; n++) digit_next[n] = digit_reg[n];

        case (state_reg)
            ST_WAIT_IDLE: begin
                if (load_lvl_reg) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (load_fall_reg) begin
                    count_next = 5'd0;
                    tcnt_next  = 16'd0;
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // A bit arriving in the same cycle as the load rise counts toward the length.
                if (sclk_rise_reg) begin
                    shift_next = {shift_reg[14:0], sdata_d_reg};
                    count_next = (count_reg == 5'd17) ? 5'd17 : count_reg + 5'd1;
                    tcnt_next  = 16'd0;
                end else begin
                    tcnt_next  = tcnt_reg + 16'd1;
                end
                if (load_rise_reg) begin
                    if (count_next == 5'd16) begin
                        state_next = ST_DECODE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_IDLE;
                    end
                end else if (!sclk_rise_reg && tcnt_reg == TO_LAST) begin
                    err_next   = 1'b1;
                    state_next = ST_WAIT_IDLE;
                end
            end
            default: begin // ST_DECODE
                state_next = ST_IDLE;
                if (frame_ok) begin
                    valid_next = 1'b1;
                    if (en_byte[7]) colon_next = seg_byte[1:0];
                    for (int n = 0; n < 4; n++)
                        if (en_byte[n]) digit_next[n] = dec[3:0];
                    if (mask_or == 5'h1F) begin
                        done_next = 1'b1;
                        mask_next = 5'd0;
                    end else begin
                        mask_next = mask_or;
                    end
                end else begin
                    err_next = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_WAIT_IDLE;
            count_reg   <= 5'd0;
            shift_reg   <= 16'd0;
            tcnt_reg    <= 16'd0;
            mask_reg    <= 5'd0;
            colon_reg   <= 2'b11;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            scan_done   <= 1'b0;
            for (int n = 0; n < 4; n++) digit_reg[n] <= 4'd0;
        end else begin
            state_reg   <= state_next;
            count_reg   <= count_next;
            shift_reg   <= shift_next;
            tcnt_reg    <= tcnt_next;
            mask_reg    <= mask_next;
            colon_reg   <= colon_next;
            frame_valid <= valid_next;
            frame_err   <= err_next;
            scan_done   <= done_next;
            for (int n = 0; n < 4; n++) digit_reg[n] <= digit_next[n];
        end
    end

    assign digit0 = digit_reg[0];
    assign digit1 = digit_reg[1];
    assign digit2 = digit_reg[2];
    assign digit3 = digit_reg[3];
    assign colon  = colon_reg;

endmodule

// File: tb/tb_seg7_serial_rx.sv
// tb_seg7_serial_rx
// Self-checking bench for seg7_serial_rx. It drives display frames on
// sclk/load/sdata. Each frame's outcome is compared with a reference model of
// the frame rules that tracks digits, colon and the slot set.
module tb_seg7_serial_rx;

    localparam int SS = 2;
    localparam int TO = 255;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk = 1'b0;
    logic       load = 1'b1;
    logic       sdata = 1'b0;
    logic [3:0] digit0, digit1, digit2, digit3;
    logic [1:0] colon;
    logic       frame_valid, frame_err, scan_done;

    seg7_serial_rx #(.SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .load(load), .sdata(sdata),
        .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
        .colon(colon), .frame_valid(frame_valid), .frame_err(frame_err),
        .scan_done(scan_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Pulse monitor: running totals plus the cycle index of the last frame_valid.
    int cyc = 0;
    int tot_valid = 0, tot_err = 0, tot_done = 0;
    int valid_cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (frame_valid) begin
            tot_valid <= tot_valid + 1;
            valid_cyc <= cyc;
        end
        if (frame_err) tot_err  <= tot_err + 1;
        if (scan_done) tot_done <= tot_done + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the display state.
    logic [6:0] code_tab [16];
    logic [3:0] m_digit [4];
    logic [1:0] m_colon;
    bit         m_seen [5];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_digit[i] = 4'd0;
        m_colon = 2'b11;
        for (int i = 0; i < 5; i++) m_seen[i] = 1'b0;
    endtask

    // Applies one frame of nbits shifts. Returns the expected pulse counts.
    task automatic model_frame(input logic [15:0] f, input int nbits,
                               output int ev, output int ee, output int ed);
        logic [7:0] seg, en;
        int nsel, slot, val, all;
        seg = f[15:8];
        en  = f[7:0];
        ev = 0; ee = 0; ed = 0;
        nsel = 0;
        slot = -1;
        if (en[7]) begin nsel++; slot = 4; end
        for (int i = 0; i < 4; i++) if (en[i]) begin nsel++; slot = i; end
        if (nbits != 16 || nsel != 1 || en[6:4] != 3'b000) begin
            ee = 1;
            return;
        end
        if (slot == 4) begin
            if (seg > 8'd3) begin ee = 1; return; end
            m_colon = seg[1:0];
        end else begin
            val = -1;
            for (int v = 0; v < 16; v++)
                if (v != 11 && val < 0 && code_tab[v] == seg[6:0]) val = v;
            if (val < 0) begin ee = 1; return; end
            m_digit[slot] = 4'(val);
        end
        ev = 1;
        m_seen[slot] = 1'b1;
        all = 1;
        for (int i = 0; i < 5; i++) if (!m_seen[i]) all = 0;
        if (all == 1) begin
            ed = 1;
            for (int i = 0; i < 5; i++) m_seen[i] = 1'b0;
        end
    endtask

    int set_cyc = 0;

    // Shifts nbits of f, MSB first. Bits past 16 are zero. The task then raises
    // load and waits for the result to settle.
    task automatic send_frame(input logic [15:0] f, input int nbits);
        @(negedge clk) load = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            sdata = (i < 16) ? f[15-i] : 1'b0;
            sclk = 1'b0;
            repeat (2) @(negedge clk);
            sclk = 1'b1;
            repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
        load = 1'b1;
        set_cyc = cyc;
        repeat (14) @(negedge clk);
    endtask

    task automatic run_frame(input string tag, input logic [15:0] f, input int nbits);
        int v0, e0, d0, ev, ee, ed;
        v0 = tot_valid; e0 = tot_err; d0 = tot_done;
        send_frame(f, nbits);
        model_frame(f, nbits, ev, ee, ed);
        check({tag, ".valid"}, 32'(tot_valid - v0), 32'(ev));
        check({tag, ".err"},   32'(tot_err - e0),   32'(ee));
        check({tag, ".done"},  32'(tot_done - d0),  32'(ed));
        check({tag, ".digits"}, {16'd0, digit3, digit2, digit1, digit0},
              {16'd0, m_digit[3], m_digit[2], m_digit[1], m_digit[0]});
        check({tag, ".colon"}, {30'd0, colon}, {30'd0, m_colon});
        $display("frame %s data=%04h bits=%0d digits=%h%h%h%h colon=%b", tag, f, nbits,
                 digit3, digit2, digit1, digit0, colon);
    endtask

    initial begin
        int v0, e0, d0, kind, idx, val;
        logic [7:0] seg, en;
        logic [15:0] fr;
        logic [3:0] vals [15];

        code_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h03, 7'h78,
                     7'h00, 7'h18, 7'h08, 7'h7F, 7'h27, 7'h21, 7'h06, 7'h0E};
        vals = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7,
                 4'h8, 4'h9, 4'hA, 4'hC, 4'hD, 4'hE, 4'hF};
        model_reset();

        // Reset state
        repeat (4) @(negedge clk);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("rst.digits", {16'd0, digit3, digit2, digit1, digit0}, 32'd0);
        check("rst.colon", {30'd0, colon}, 32'd3);
        check("rst.pulses", 32'(tot_valid + tot_err + tot_done), 32'd0);

        // Driver-format frame, with a latency check
        run_frame("d0_one", 16'hF901, 16);
        check("latency", 32'(valid_cyc - set_cyc - 1), 32'(SS + 2));

        // Full scan
        run_frame("scan_d3", {8'h18, 8'h08}, 16);
        run_frame("scan_d2", {8'h40, 8'h04}, 16);
        run_frame("scan_d1", {8'h19, 8'h02}, 16);
        run_frame("scan_d0", {8'h0E, 8'h01}, 16);
        run_frame("scan_col", 16'h0080, 16);

        // Wrong lengths, then a good frame
        run_frame("len15", {8'h24, 8'h01}, 15);
        run_frame("len17", {8'h24, 8'h01}, 17);
        run_frame("len_ok", {8'h24, 8'h01}, 16);

        // Bad enables, bad codes
        run_frame("en03", {8'h24, 8'h03}, 16);
        run_frame("en10", {8'h24, 8'h10}, 16);
        run_frame("seg7f", {8'h7F, 8'h02}, 16);
        run_frame("col04", {8'h04, 8'h80}, 16);

        // Code 03 with DP set decodes to 6
        run_frame("d2_six", {8'h83, 8'h04}, 16);

        // Timeout: stall sclk mid-frame, then resync
        v0 = tot_valid; e0 = tot_err;
        @(negedge clk) load = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            sdata = 1'b1; sclk = 1'b0; repeat (2) @(negedge clk);
            sclk = 1'b1; repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
        repeat (TO + 12) @(negedge clk);
        check("timeout.err", 32'(tot_err - e0), 32'd1);
        load = 1'b1;
        repeat (14) @(negedge clk);
        check("timeout.valid", 32'(tot_valid - v0), 32'd0);
        check("timeout.err_once", 32'(tot_err - e0), 32'd1);
        run_frame("after_to", {8'h30, 8'h08}, 16);

        // Reset at bit 8 of a frame
        v0 = tot_valid; e0 = tot_err; d0 = tot_done;
        fr = {8'h12, 8'h01};
        @(negedge clk) load = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) begin
                reset = 1'b1;
                repeat (3) @(negedge clk);
                reset = 1'b0;
                repeat (2) @(negedge clk);
                model_reset();
                check("rstmid.digits", {16'd0, digit3, digit2, digit1, digit0}, 32'd0);
                check("rstmid.colon", {30'd0, colon}, 32'd3);
            end
            sdata = fr[15-i]; sclk = 1'b0; repeat (2) @(negedge clk);
            sclk = 1'b1; repeat (2) @(negedge clk);
        end
        sclk = 1'b0;
        load = 1'b1;
        repeat (14) @(negedge clk);
        check("rstmid.pulses", 32'((tot_valid - v0) + (tot_err - e0) + (tot_done - d0)), 32'd0);
        check("rstmid.digits2", {16'd0, digit3, digit2, digit1, digit0}, 32'd0);
        run_frame("after_rst", {8'h78, 8'h02}, 16);

        // Randomized frames
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 9));
            idx  = int'($urandom_range(0, 3));
            if (kind <= 6) begin
                val = int'($urandom_range(0, 14));
                seg = {1'($urandom_range(0, 1)), code_tab[vals[val]]};
                en  = 8'(1 << idx);
            end else if (kind == 7) begin
                seg = {6'd0, 2'($urandom_range(0, 3))};
                en  = 8'h80;
            end else if (kind == 8) begin
                seg = {1'b0, code_tab[vals[int'($urandom_range(0, 14))]]};
                en  = 8'($urandom);
            end else begin
                seg = 8'($urandom);
                en  = 8'(1 << idx);
            end
            run_frame($sformatf("rnd%0d", t), {seg, en}, 16);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
